// File: rtl/vga_blit_master.sv
`timescale 1ns/1ps
// vga_blit_master: Avalon-MM master that copies an 8-bit pixel rectangle from
// word-addressed memory into the 160x120 VGA pixel slave, one pixel write per
// byte, with a small CSR slave port for programming and status polling.
//
// state | meaning
// IDLE  | waiting for a CTRL write
// FETCH | read request for the current source word is on the bus
// WAIT  | read accepted, waiting for m_readdatavalid
// PLOT  | writing the visible lanes of the fetched word to the VGA slave
// DONE  | transfer finished, status flips to done on the way back to IDLE
module vga_blit_master (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  s_address,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic        m_waitrequest
);

    localparam logic [31:0] VGA_BASE = 32'h0000_4000;
    localparam logic [8:0]  SCR_W    = 9'd160;
    localparam logic [7:0]  SCR_H    = 8'd120;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLOT, DONE} state_t;

    state_t      state;
    logic [31:0] src_q;
    logic [31:0] dims_q;
    logic [7:0]  wid_q;
    logic [6:0]  hgt_q;
    logic [7:0]  xw_q;
    logic [7:0]  y_q;
    logic [31:0] row_addr;
    logic [31:0] word_addr;
    logic [31:0] data_q;
    logic [1:0]  lane_q;
    logic        busy;
    logic        done;

    logic [8:0]  lane_x [4];
    logic [3:0]  lane_ok;
    logic [3:0]  lane_hi;
    logic [2:0]  first0;
    logic [2:0]  firstn;
    logic [8:0]  w_round;
    logic [31:0] stride;
    logic [31:0] nx_word;
    logic        more_in_row;
    logic        more_rows;
    logic        do_adv;

    // Lowest set bit of a lane mask as {found, index}.
    function automatic logic [2:0] pick(input logic [3:0] m);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--)
            if (m[i]) r = {1'b1, 2'(i)};
        return r;
    endfunction

    // Pixel write word for lane k of source word d.
    function automatic logic [31:0] pix(input logic [31:0] d, input logic [1:0] k,
                                        input logic [7:0] xw, input logic [6:0] y);
        logic [7:0] x;
        logic [7:0] c;
        x = xw + {6'b0, k};
        c = 8'(d >> {k, 3'b000});
        return {1'b0, y, x, 8'h00, c};
    endfunction

    // Lane visibility and the walk through words and rows; lane skipping is
    // combinational so an invisible lane costs no cycle.
    always_comb begin
        lane_ok = '0;
        lane_hi = '0;
        for (int k = 0; k < 4; k++) begin
            lane_x[k]  = {1'b0, xw_q} + 9'(k);
            lane_ok[k] = (lane_x[k] < {1'b0, wid_q}) && (lane_x[k] < SCR_W) && (y_q < SCR_H);
            lane_hi[k] = lane_ok[k] && (2'(k) > lane_q);
        end
        first0      = pick(lane_ok);
        firstn      = pick(lane_hi);
        w_round     = {1'b0, wid_q} + 9'd3;
        stride      = {23'b0, w_round} & ~32'd3;
        more_in_row = ({1'b0, xw_q} + 9'd4) < {1'b0, wid_q};
        more_rows   = ({1'b0, y_q} + 9'd1) < {2'b0, hgt_q};
        nx_word     = more_in_row ? word_addr + 32'd4 : row_addr + stride;
        do_adv      = ((state == WAIT) && m_readdatavalid && !first0[2]) ||
                      ((state == PLOT) && !m_waitrequest && !firstn[2]);
    end

    // CSR read mux, valid in the cycle s_read is asserted.
    always_comb begin
        s_readdata = 32'd0;
        if (s_read) begin
            case (s_address)
                4'd0:    s_readdata = {30'b0, done, busy};
                4'd1:    s_readdata = src_q;
                4'd2:    s_readdata = dims_q;
                default: s_readdata = 32'd0;
            endcase
        end
    end

    // CSR storage; the running transfer works from its own latched copies.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            src_q  <= 32'd0;
            dims_q <= 32'd0;
        end else if (s_write) begin
            if (s_address == 4'd1) src_q  <= {s_writedata[31:2], 2'b00};
            if (s_address == 4'd2) dims_q <= s_writedata;
        end
    end

    // Transfer FSM with registered master outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            wid_q       <= 8'd0;
            hgt_q       <= 7'd0;
            xw_q        <= 8'd0;
            y_q         <= 8'd0;
            row_addr    <= 32'd0;
            word_addr   <= 32'd0;
            data_q      <= 32'd0;
            lane_q      <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_address   <= 32'd0;
            m_writedata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_write && s_address == 4'd0) begin
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        wid_q     <= dims_q[7:0];
                        hgt_q     <= dims_q[22:16];
                        xw_q      <= 8'd0;
                        y_q       <= 8'd0;
                        row_addr  <= src_q;
                        word_addr <= src_q;
                        if (dims_q[7:0] != 8'd0 && dims_q[22:16] != 7'd0) begin
                            state     <= FETCH;
                            m_read    <= 1'b1;
                            m_address <= src_q;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (!m_waitrequest) begin
                        m_read <= 1'b0;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_readdatavalid) begin
                        data_q <= m_readdata;
                        if (first0[2]) begin
                            state       <= PLOT;
                            lane_q      <= first0[1:0];
                            m_write     <= 1'b1;
                            m_address   <= VGA_BASE;
                            m_writedata <= pix(m_readdata, first0[1:0], xw_q, y_q[6:0]);
                        end
                    end
                end
                PLOT: begin
                    if (!m_waitrequest) begin
                        if (firstn[2]) begin
                            lane_q      <= firstn[1:0];
                            m_writedata <= pix(data_q, firstn[1:0], xw_q, y_q[6:0]);
                        end else begin
                            m_write <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (do_adv) begin
                if (more_in_row) begin
                    xw_q <= xw_q + 8'd4;
                end else begin
                    xw_q     <= 8'd0;
                    y_q      <= y_q + 8'd1;
                    row_addr <= row_addr + stride;
                end
                word_addr <= nx_word;
                if (more_in_row || more_rows) begin
                    state     <= FETCH;
                    m_read    <= 1'b1;
                    m_address <= nx_word;
                end else begin
                    state <= DONE;
                end
            end
        end
    end

endmodule

// File: doc/vga_blit_master.md
# vga_blit_master

Avalon-MM master that copies an 8-bit monochrome pixel rectangle from word-addressed memory into the 160x120 VGA pixel slave. It issues the same single-word pixel writes a CPU would: colour in [7:0], x in [23:16], y in [30:24], at slave offset 0. Software programs it through a small CSR slave port and polls for completion. It sits on the system interconnect alongside the CPU, as a second master targeting the VGA slave.

## Interface
- VGA_BASE, 32'h0000_4000: byte address of the VGA pixel slave offset 0.
- SCR_W, 160: screen width; pixels with x >= SCR_W are not written.
- SCR_H, 120: screen height; pixels with y >= SCR_H are not written.

- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- s_address  in  4  CSR word offset
- s_read  in  1  CSR read strobe; s_readdata is valid in the same cycle (combinational)
- s_readdata  out  32  CSR read data
- s_write  in  1  CSR write strobe
- s_writedata  in  32  CSR write data
- m_address  out  32  master byte address
- m_read  out  1  master read request
- m_readdata  in  32  master read data
- m_readdatavalid  in  1  read data valid
- m_write  out  1  master write request
- m_writedata  out  32  master write data (pixel word)
- m_waitrequest  in  1  slave stall

## Operation
- CSR map:
  - 0 CTRL: any write starts a transfer when idle. Read returns {30'b0, done, busy}.
  - 1 SRC: byte address; bits [1:0] are forced to 0.
  - 2 DIMS: width [7:0], height [22:16]. Read returns the stored value.
  - Unmapped offsets read 0; writes to them are ignored.
- Source layout:
  - Row stride = ceil(width/4)*4 bytes.
  - Pixel (x,y) is the byte at SRC + y*stride + x.
  - Little-endian packing: byte 0 of a word is the lowest x.
- Start:
  - SRC and DIMS are latched into working registers; busy=1, done=0.
  - A CTRL write while busy is ignored.
  - SRC/DIMS writes while busy update the CSRs only; the running transfer is unaffected.
- FSM states: IDLE, FETCH, WAIT, PLOT, DONE.
  - IDLE -> FETCH on start with width!=0 and height!=0.
  - IDLE -> DONE on start with width==0 or height==0.
  - FETCH: m_read=1, m_address=current word address. Advance to WAIT in the cycle m_waitrequest==0.
  - WAIT: hold until m_readdatavalid. Then latch m_readdata and enter PLOT with lane 0. At most one read is outstanding.
  - PLOT, for each lane k=0..3 with pixel x = xw+k:
    - If x < width, x < SCR_W and y < SCR_H: assert m_write with m_address=VGA_BASE and m_writedata={1'b0, y[6:0], x[7:0], 8'h00, byte k}. Hold until m_waitrequest==0.
    - Otherwise skip the lane in zero cycles (combinational lane skip; no dead cycle).
    - After lane 3, or when x reaches width: advance.
  - Advance:
    - Next word in the row (xw += 4) if xw+4 < width.
    - Otherwise next row (xw=0, y++, row address += stride).
    - After the last row -> DONE.
  - DONE: busy=0, done=1 for one cycle, then -> IDLE. done stays readable as 1 until the next start.
- Master outputs (address, data, read, write) are registered and stay stable while m_waitrequest=1. m_read and m_write are never asserted together.
- Arithmetic:
  - x and y counters are 8 bits. width ≤ 255, height ≤ 127.
  - Row address is accumulated, not multiplied.
  - Address wrap at 2^32 is modulo.

## Timing
- Reset: m_read=0, m_write=0, m_address=0, m_writedata=0, s_readdata=0 when not reading, CTRL/SRC/DIMS=0, busy=0, done=0, FSM=IDLE.
- Reset mid-transfer:
  - Takes effect at the next edge.
  - Any pending request is dropped.
  - Late m_readdatavalid while in IDLE is ignored.
- Start latency: CTRL write in cycle N -> m_read=1 in cycle N+1.
- Per full word with zero waitstates and read latency L: 1 (FETCH) + L (WAIT) + 4 (PLOT) cycles.
- Zero-size start at cycle N: done=1 readable from cycle N+2.

## Test plan
- SRC=0x100, DIMS width=4 height=2, memory words 0x44332211 / 0x88776655, zero waitstates:
  - Required: exactly 8 writes to VGA_BASE.
  - First write is 0x00000011, fifth write is 0x01000055.
  - done=1 afterwards.
- Width=5 height=1:
  - Two reads, at 0x100 and 0x104.
  - 5 writes; the last has x=4 and colour = byte 0 of the second word.
  - Row stride is 8.
- Random m_waitrequest (50%) and read latency 1-4:
  - Address/data are stable during every stall.
  - Pixel sequence is identical to the zero-wait run.
- Width=200 height=1 at SRC=0:
  - 50 reads.
  - Exactly 160 writes (x 0..159); no write has x≥160.
- DIMS width=0: start -> no m_read or m_write; status reads 2'b10 within 2 cycles.
- Start, then reset_n=0 during PLOT:
  - Next cycle m_write=0, status=0.
  - A second CTRL write issued while busy (before reset) causes no restart; write count is unchanged.
